// File: rtl/r5p_gpio_debounce.sv
// GPIO pad conditioning: per-bit synchronizer, prescaled glitch filter, registered level.
// Define R5P_GPIO_EDGE_EN to build the registered rise/fall event pulses; otherwise they are tied low.
module r5p_gpio_debounce #(
    parameter int unsigned    GW      = 1,
    parameter int unsigned    SYNC    = 2,
    parameter int unsigned    PRE     = 50000,
    parameter int unsigned    DEB     = 4,
    parameter logic [GW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [GW-1:0] pad_i,
    output logic [GW-1:0] gpio_i,
    output logic [GW-1:0] rise,
    output logic [GW-1:0] fall
);

    localparam int unsigned PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int unsigned DW = $clog2(DEB + 1);

    localparam logic [0:0] STABLE = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;

    logic [SYNC-1:0][GW-1:0] sync_q;
    logic [GW-1:0]           s;
    logic [PW-1:0]           pc_q;
    logic                    tick_c;
    logic [GW-1:0]           state_q;
    logic [GW-1:0]           state_d;
    logic [GW-1:0][DW-1:0]   dc_q;
    logic [GW-1:0][DW-1:0]   dc_d;
    logic [GW-1:0]           gpio_d;

    // Pad synchronizer chain; stage SYNC-1 is the usable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC-2:0], pad_i};
        end
    end

    assign s = sync_q[SYNC-1];

    // Shared free-running prescaler setting the settle time base.
    assign tick_c = (pc_q == PW'(PRE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (tick_c) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= {GW{STABLE}};
            dc_q    <= '0;
            gpio_i  <= RST_VAL;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            gpio_i  <= gpio_d;
        end
    end

    // Per-bit filter: a tick in the SETTLE entry cycle is not counted, and a
    // returning level (glitch end) wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        gpio_d  = gpio_i;
        for (int i = 0; i < int'(GW); i++) begin
            case (state_q[i])
                STABLE: begin
                    if (s[i] != gpio_i[i]) begin
                        state_d[i] = SETTLE;
                        dc_d[i]    = '0;
                    end
                end
                default: begin
                    if (s[i] == gpio_i[i]) begin
                        state_d[i] = STABLE;
                        dc_d[i]    = '0;
                    end else if (tick_c) begin
                        if (dc_q[i] == DW'(DEB - 1)) begin
                            gpio_d[i]  = s[i];
                            state_d[i] = STABLE;
                            dc_d[i]    = '0;
                        end else begin
                            dc_d[i] = dc_q[i] + DW'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef R5P_GPIO_EDGE_EN
    // Event pulses land in the same cycle as the level update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= gpio_d & ~gpio_i;
            fall <= ~gpio_d & gpio_i;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_r5p_gpio_debounce.sv
// Randomized self-checking bench for r5p_gpio_debounce against a tick-counting reference model.
module tb_r5p_gpio_debounce;

    localparam int GW   = 2;
    localparam int SYNC = 2;
    localparam int PRE  = 4;
    localparam int DEB  = 3;

`ifdef R5P_GPIO_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [GW-1:0] pad_i;
    logic [GW-1:0] gpio_i;
    logic [GW-1:0] rise;
    logic [GW-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    r5p_gpio_debounce #(
        .GW(GW), .SYNC(SYNC), .PRE(PRE), .DEB(DEB), .RST_VAL(2'b00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pad_i(pad_i),
        .gpio_i(gpio_i), .rise(rise), .fall(fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pad delayed SYNC cycles, a level is accepted once DEB
    // prescaler ticks have elapsed while mismatched, the first mismatched cycle's tick excluded.
    logic [GW-1:0] m_sync [SYNC];
    logic [GW-1:0] m_gpio, m_rise, m_fall, m_ng;
    int            m_pc;
    bit            m_tick;
    int            m_run   [GW];
    int            m_ticks [GW];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
            m_gpio = '0; m_rise = '0; m_fall = '0; m_pc = 0;
            for (int b = 0; b < GW; b++) begin m_run[b] = 0; m_ticks[b] = 0; end
        end else begin
            m_tick = (m_pc == PRE - 1);
            m_pc   = (m_pc + 1) % PRE;
            m_ng   = m_gpio;
            for (int b = 0; b < GW; b++) begin
                if (m_sync[SYNC-1][b] != m_gpio[b]) begin
                    if (m_run[b] > 0 && m_tick) m_ticks[b]++;
                    m_run[b]++;
                    if (m_ticks[b] == DEB) begin
                        m_ng[b] = m_sync[SYNC-1][b];
                        m_run[b] = 0; m_ticks[b] = 0;
                    end
                end else begin
                    m_run[b] = 0; m_ticks[b] = 0;
                end
            end
            m_rise = EDGE_EN ? (m_ng & ~m_gpio) : '0;
            m_fall = EDGE_EN ? (~m_ng & m_gpio) : '0;
            m_gpio = m_ng;
            for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = pad_i;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        pad_i = 2'b11;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gpio_i !== 2'b00) begin n_fail++; $display("FAIL reset_gpio: got %b want 00", gpio_i); end
        n_checks++;
        if (rise !== 2'b00) begin n_fail++; $display("FAIL reset_rise: got %b want 00", rise); end
        n_checks++;
        if (fall !== 2'b00) begin n_fail++; $display("FAIL reset_fall: got %b want 00", fall); end
    endtask

    task automatic test_reset_release();
        int rcnt0 = 0, rcnt1 = 0, lat = 0;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL release cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
            if (rise[0] === 1'b1) rcnt0++;
            if (rise[1] === 1'b1) rcnt1++;
            if (lat == 0 && gpio_i === 2'b11) lat = k;
        end
        n_checks++;
        if (lat != 12) begin n_fail++; $display("FAIL release_latency: got %0d want 12", lat); end
        n_checks++;
        if (rcnt0 != int'(EDGE_EN) || rcnt1 != int'(EDGE_EN)) begin
            n_fail++; $display("FAIL release_rise_count: got %0d/%0d want %0d", rcnt0, rcnt1, int'(EDGE_EN));
        end
    endtask

    task automatic settle(input logic [GW-1:0] lvl, input int cycles);
        pad_i = lvl;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL settle cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_glitch();
        bit bad = 1'b0;
        settle(2'b00, 20);
        pad_i[0] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k == 5) pad_i[0] = 1'b0;
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
            if (gpio_i[0] !== 1'b0 || rise[0] !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL glitch_rejected: gpio0/rise0 went high, want 0"); end
    endtask

    task automatic test_latency(input int phase, input int exp_lat);
        int lat = 0, rcnt = 0, guard = 0;
        settle(2'b00, 20);
        while (m_pc != phase && guard < 2 * PRE) begin @(negedge clk); guard++; end
        pad_i[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL latency cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
            if (rise[0] === 1'b1) rcnt++;
            if (lat == 0 && gpio_i[0] === 1'b1) lat = k;
        end
        n_checks++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL latency_phase%0d: got %0d want %0d", phase, lat, exp_lat); end
        n_checks++;
        if (rcnt != int'(EDGE_EN)) begin n_fail++; $display("FAIL latency_rise_count: got %0d want %0d", rcnt, int'(EDGE_EN)); end
    endtask

    task automatic test_both_bits();
        int kf = 0, kr = 0, kg = 0;
        settle(2'b01, 25);
        pad_i = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL both cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
            if (kf == 0 && fall[0] === 1'b1) kf = k;
            if (kr == 0 && rise[1] === 1'b1) kr = k;
            if (kg == 0 && gpio_i === 2'b10) kg = k;
        end
        n_checks++;
        if (kg == 0) begin n_fail++; $display("FAIL both_accept: gpio never reached 10"); end
        n_checks++;
        if (EDGE_EN ? (kf != kg || kr != kg) : (kf != 0 || kr != 0)) begin
            n_fail++; $display("FAIL both_events: fall0 at %0d rise1 at %0d, gpio update at %0d", kf, kr, kg);
        end
    endtask

    task automatic test_reset_mid_settle();
        int guard = 0, lat = 0;
        settle(2'b00, 25);
        pad_i[0] = 1'b1;
        while (m_ticks[0] != 1 && guard < 20) begin @(negedge clk); guard++; end
        n_checks++;
        if (m_ticks[0] != 1) begin n_fail++; $display("FAIL midreset_reach: tick count %0d want 1", m_ticks[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gpio_i !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
            n_fail++; $display("FAIL midreset_async: gpio=%b rise=%b fall=%b want 00 00 00", gpio_i, rise, fall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL midreset cyc %0d: gpio=%b rise=%b fall=%b want %b %b %b", k, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
            end
            if (lat == 0 && gpio_i[0] === 1'b1) lat = k;
        end
        n_checks++;
        if (lat != 12) begin n_fail++; $display("FAIL midreset_latency: got %0d want 12", lat); end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 120; seg++) begin
            pad_i = GW'($urandom);
            hold  = (seg % 3 == 0) ? int'($urandom_range(14, 24)) : int'($urandom_range(1, 12));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                n_checks++;
                if (gpio_i !== m_gpio || rise !== m_rise || fall !== m_fall) begin
                    n_fail++;
                    $display("FAIL random seg %0d: gpio=%b rise=%b fall=%b want %b %b %b", seg, gpio_i, rise, fall, m_gpio, m_rise, m_fall);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_glitch();
        test_latency(0, 12);
        test_latency(1, 15);
        test_both_bits();
        test_reset_mid_settle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
